// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types for the round-robin bus arbiter: FSM encoding, bus op codes, index sizing.
// Used by the arbiter top and by the bench so both agree on encodings.
package bus_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_READ  = 1'b1;
    localparam logic OP_WRITE = 1'b0;

    // A single requester still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Requester-side and memory-bus-side signal bundle of the arbiter.
// master = requesters plus memory block; slave = the arbiter itself.
interface bus_arbiter_rr_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        rd_op;
    logic [NUM_REQ*ADDR_W-1:0] addr_in;
    logic [NUM_REQ*DATA_W-1:0] wdata_in;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rdata_out;
    logic                      timeout_err;
    logic                      bus_access;
    logic                      bus_read_op;
    logic [ADDR_W-1:0]         bus_addr;
    logic [DATA_W-1:0]         bus_wdata;
    logic [DATA_W-1:0]         bus_rdata;
    logic                      bus_finish;

    modport master (
        output req, rd_op, addr_in, wdata_in, bus_rdata, bus_finish,
        input  gnt, done, rdata_out, timeout_err, bus_access, bus_read_op, bus_addr, bus_wdata
    );

    modport slave (
        input  req, rd_op, addr_in, wdata_in, bus_rdata, bus_finish,
        output gnt, done, rdata_out, timeout_err, bus_access, bus_read_op, bus_addr, bus_wdata
    );
endinterface

// File: rtl/bus_arbiter_rr_rr_pick.sv
// Combinational round-robin winner: first requester above last_gnt, wrapping modulo NUM_REQ.
// Zero latency; vld low when nobody requests.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] win,
    output logic               vld
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        win  = '0;
        vld  = 1'b0;
        cand = '0;
        // Offset 1..NUM_REQ so the last winner is considered only after everyone else.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
            if (!vld && req[cand]) begin
                win[cand] = 1'b1;
                vld       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter serialising NUM_REQ cache controllers onto one memory bus; req->bus_access 1 cycle.
// Backpressure: requesters hold req until their done pulse; the bus paces completion via bus_finish or timeout.
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    bus_arbiter_rr_if.slave bif
);
    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d, last_q, last_d, pick_idx;
    logic                rd_q, rd_d, err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  pick_win, idx_oh;
    logic                pick_vld;
    logic                busy;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) rp0 (
        .req      (bif.req),
        .last_gnt (last_q),
        .win      (pick_win),
        .vld      (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_win[i]) pick_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        rd_d    = rd_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    idx_d   = pick_idx;
                    rd_d    = bif.rd_op[pick_idx];
                    addr_d  = bif.addr_in[int'(pick_idx)*ADDR_W +: ADDR_W];
                    wdata_d = bif.wdata_in[int'(pick_idx)*DATA_W +: DATA_W];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A finish on the last allowed cycle still counts as a clean completion.
                if (bif.bus_finish) begin
                    if (rd_q == OP_READ) rdata_d = bif.bus_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                last_d  = idx_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy   = (state_q == ST_BUSY);
    assign idx_oh = NUM_REQ'(1) << idx_q;

    assign bif.gnt         = (state_q != ST_IDLE) ? idx_oh : '0;
    assign bif.done        = (state_q == ST_DONE) ? idx_oh : '0;
    assign bif.timeout_err = (state_q == ST_DONE) && err_q;
    assign bif.bus_access  = busy;
    assign bif.bus_read_op = busy ? rd_q : OP_WRITE;
    assign bif.bus_addr    = busy ? addr_q : '0;
    assign bif.bus_wdata   = busy ? wdata_q : '0;
    assign bif.rdata_out   = rdata_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: queued expectations from a service-order model, checked by a negedge monitor.
module tb_bus_arbiter_rr;
    localparam int NR = 2;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 8;

    typedef struct { bit rd; logic [AW-1:0] addr; logic [DW-1:0] wdata; int lat; logic [DW-1:0] rdata; } txn_t;
    typedef struct { int idx; bit rd; logic [AW-1:0] addr; logic [DW-1:0] wdata;
                     logic [DW-1:0] rdata; bit err; int busy; int gap; } exp_t;
    typedef struct { int lat; logic [DW-1:0] rdata; } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_arbiter_rr_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bif ();

    bus_arbiter_rr #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    txn_t tq[NR][$];
    exp_t exp_q[$];
    rsp_t rsp_q[$];
    int pos[NR];
    int n_checks = 0;
    int n_fail   = 0;
    int m_last   = NR - 1;
    logic [DW-1:0] m_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int rand_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(1, 5);
        if (r < 8) return TO;
        return TO + 1 + $urandom_range(0, 3);
    endfunction

    function automatic txn_t mk(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] w,
                                input int lat, input logic [DW-1:0] rdat);
        txn_t t;
        t.rd = rd; t.addr = a; t.wdata = w; t.lat = lat; t.rdata = rdat;
        return t;
    endfunction

    function automatic txn_t rnd_txn(input int lat);
        return mk(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), lat, DW'($urandom));
    endfunction

    // Service order: repeatedly take the next requester (cyclically after the last served) with work left.
    task automatic plan();
        int rem[NR];
        int cur, j, total;
        bit first;
        exp_t e;
        rsp_t r;
        txn_t t;
        total = 0;
        for (int k = 0; k < NR; k++) begin
            rem[k] = tq[k].size();
            total += rem[k];
        end
        cur = m_last;
        first = 1'b1;
        while (total > 0) begin
            j = cur;
            for (int k = 1; k <= NR; k++) begin
                if (rem[(cur + k) % NR] > 0) begin
                    j = (cur + k) % NR;
                    break;
                end
            end
            t = tq[j][tq[j].size() - rem[j]];
            e.idx = j; e.rd = t.rd; e.addr = t.addr; e.wdata = t.wdata;
            if (t.lat <= TO) begin
                e.busy = t.lat; e.err = 1'b0;
                if (t.rd) m_rdata = t.rdata;
            end else begin
                e.busy = TO; e.err = 1'b1;
            end
            e.rdata = m_rdata;
            e.gap = first ? -1 : 2;
            first = 1'b0;
            exp_q.push_back(e);
            r.lat = t.lat; r.rdata = t.rdata;
            rsp_q.push_back(r);
            rem[j]--; total--; cur = j;
        end
        m_last = cur;
    endtask

    task automatic present(input int k);
        txn_t t;
        t = tq[k][pos[k]];
        bif.req[k] = 1'b1;
        bif.rd_op[k] = t.rd;
        bif.addr_in[k*AW +: AW] = t.addr;
        bif.wdata_in[k*DW +: DW] = t.wdata;
    endtask

    task automatic drive(input bit scramble);
        int left, budget;
        left = 0;
        for (int k = 0; k < NR; k++) begin
            pos[k] = 0;
            left += tq[k].size();
            if (tq[k].size() > 0) present(k);
        end
        budget = 0;
        while (left > 0 && budget < 2000) begin
            @(posedge clk);
            #1;
            budget++;
            for (int k = 0; k < NR; k++) begin
                if (bif.done[k]) begin
                    pos[k]++;
                    left--;
                    if (pos[k] < tq[k].size()) present(k);
                    else bif.req[k] = 1'b0;
                end else if (scramble && bif.bus_access && bif.gnt[k] && $urandom_range(0, 3) == 0) begin
                    bif.addr_in[k*AW +: AW] = AW'($urandom);
                    bif.wdata_in[k*DW +: DW] = DW'($urandom);
                    bif.rd_op[k] = ~bif.rd_op[k];
                    if (pos[k] == tq[k].size() - 1) bif.req[k] = 1'b0;
                end
            end
        end
        if (left > 0) begin
            n_checks++; n_fail++;
            $display("FAIL batch_wait: %0d transactions outstanding, required 0", left);
            bif.req = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("exp_drained", 64'(exp_q.size()), 64'd0);
        for (int k = 0; k < NR; k++) tq[k].delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 64'(bif.gnt), 64'd0);
        chk({tag, "_done"}, 64'(bif.done), 64'd0);
        chk({tag, "_terr"}, 64'(bif.timeout_err), 64'd0);
        chk({tag, "_access"}, 64'(bif.bus_access), 64'd0);
        chk({tag, "_rdop"}, 64'(bif.bus_read_op), 64'd0);
        chk({tag, "_addr"}, 64'(bif.bus_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(bif.bus_wdata), 64'd0);
        chk({tag, "_rdata"}, 64'(bif.rdata_out), 64'd0);
    endtask

    // Memory side: per transaction, finish after the planned latency; stray finishes while idle.
    int r_busy = 0;
    bit r_in_txn = 1'b0;
    rsp_t r_cur;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            r_in_txn = 1'b0;
            bif.bus_finish = 1'b0;
        end else if (bif.bus_access) begin
            if (!r_in_txn) begin
                r_in_txn = 1'b1;
                r_busy = 0;
                if (rsp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL bus_start: bus_access with no planned transaction at %0t", $time);
                    r_cur.lat = 1; r_cur.rdata = '0;
                end else begin
                    r_cur = rsp_q.pop_front();
                end
            end
            r_busy++;
            bif.bus_finish = (r_busy == r_cur.lat);
            bif.bus_rdata = bif.bus_finish ? r_cur.rdata : DW'($urandom);
        end else begin
            r_in_txn = 1'b0;
            bif.bus_finish = ($urandom_range(0, 3) == 0);
            bif.bus_rdata = DW'($urandom);
        end
    end

    int cyc = 0;
    int last_done_cyc = 0;
    int m_busy = 0;
    bit m_in_busy = 1'b0;
    bit post_done = 1'b0;
    exp_t me;
    always @(negedge clk) begin
        if (rst) begin
            m_in_busy = 1'b0;
            m_busy = 0;
            post_done = 1'b0;
        end else begin
            cyc++;
            if (post_done) begin
                post_done = 1'b0;
                chk("idle_after_done", 64'({bif.bus_access, bif.gnt, bif.done}), 64'd0);
            end
            if (bif.bus_access) begin
                if (!m_in_busy) begin
                    m_in_busy = 1'b1;
                    m_busy = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL grant: bus_access with empty expectation queue at %0t", $time);
                    end else if (exp_q[0].gap >= 0) begin
                        chk("turnaround", 64'(cyc - last_done_cyc), 64'(exp_q[0].gap));
                    end
                end
                m_busy++;
                if (exp_q.size() > 0) begin
                    chk("bus_read_op", 64'(bif.bus_read_op), 64'(exp_q[0].rd));
                    chk("bus_addr", 64'(bif.bus_addr), 64'(exp_q[0].addr));
                    chk("bus_wdata", 64'(bif.bus_wdata), 64'(exp_q[0].wdata));
                    chk("gnt_busy", 64'(bif.gnt), 64'd1 << exp_q[0].idx);
                end
            end
            if (bif.done != '0) begin
                m_in_busy = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL done: pulse %0b with empty expectation queue at %0t", bif.done, $time);
                end else begin
                    me = exp_q.pop_front();
                    chk("done", 64'(bif.done), 64'd1 << me.idx);
                    chk("gnt_done", 64'(bif.gnt), 64'd1 << me.idx);
                    chk("timeout_err", 64'(bif.timeout_err), 64'(me.err));
                    chk("rdata_out", 64'(bif.rdata_out), 64'(me.rdata));
                    chk("busy_cycles", 64'(m_busy), 64'(me.busy));
                    chk("access_in_done", 64'(bif.bus_access), 64'd0);
                end
                last_done_cyc = cyc;
                post_done = 1'b1;
            end else begin
                chk("terr_quiet", 64'(bif.timeout_err), 64'd0);
            end
        end
    end

    initial begin
        int w;
        bif.req = '0; bif.rd_op = '0; bif.addr_in = '0; bif.wdata_in = '0;
        bif.bus_finish = 1'b0; bif.bus_rdata = '0;
        #12;
        check_all_zero("reset");
        #11 rst = 1'b0;

        // Single read, finish on the third BUSY cycle.
        tq[0].push_back(mk(1'b1, 8'h3C, 8'h00, 3, 8'hA5));
        plan(); drive(1'b0);

        // Write from requester 1: rdata_out must keep A5.
        tq[1].push_back(mk(1'b0, 8'h10, 8'h5A, 4, 8'hEE));
        plan(); drive(1'b0);

        // Both requesters held high for two transactions each: alternation 0,1,0,1.
        for (int k = 0; k < 2; k++) begin
            tq[0].push_back(rnd_txn($urandom_range(1, 4)));
            tq[1].push_back(rnd_txn($urandom_range(1, 4)));
        end
        plan(); drive(1'b0);

        // Hung bus for requester 0, then a normal request from requester 1.
        tq[0].push_back(mk(1'b1, 8'h77, 8'h00, TO + 5, 8'h11));
        tq[1].push_back(mk(1'b1, 8'h42, 8'h00, 2, 8'hC9));
        plan(); drive(1'b0);

        // Asynchronous reset in the middle of a BUSY phase.
        tq[1].push_back(mk(1'b1, 8'hC3, 8'h00, TO + 5, 8'h00));
        plan();
        pos[1] = 0;
        present(1);
        w = 0;
        while (!bif.bus_access && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("reset_test_busy", 64'(bif.bus_access), 64'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        bif.req = '0;
        #1;
        check_all_zero("async_rst");
        exp_q.delete(); rsp_q.delete(); tq[1].delete();
        m_last = NR - 1;
        m_rdata = '0;
        @(posedge clk);
        #2 rst = 1'b0;

        // After reset requester 0 wins first again.
        tq[0].push_back(rnd_txn(2));
        tq[1].push_back(rnd_txn(3));
        plan(); drive(1'b0);

        for (int b = 0; b < 40; b++) begin
            for (int k = 0; k < NR; k++) begin
                int n;
                n = $urandom_range(0, 3);
                for (int t = 0; t < n; t++) tq[k].push_back(rnd_txn(rand_lat()));
            end
            plan(); drive(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
